// File: rtl/alu_issue.sv
// Operand issue stage feeding the ALU: a small operand FIFO, a one-cycle issue strobe,
// and a latency-matched tracker that stands in for the ALU's missing result-valid.
module alu_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned KEY_W   = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           stall,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_a,
    input  logic [31:0]                    req_b,
    input  logic [KEY_W-1:0]               req_key,
    output logic                           alu_en,
    output logic                           alu_clr,
    output logic [31:0]                    alu_a,
    output logic [31:0]                    alu_b,
    output logic [KEY_W-1:0]               alu_key,
    output logic                           done,
    output logic [KEY_W-1:0]               done_key,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [31:0]      mem_a   [DEPTH];
    logic [31:0]      mem_b   [DEPTH];
    logic [KEY_W-1:0] mem_key [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_c;
    logic             pop_c;

    logic [LATENCY-1:0] trk_v;
    logic [KEY_W-1:0]   trk_k [LATENCY];

    // No bypass: pop only looks at already-stored entries, so a fresh write waits a cycle.
    always_comb begin
        req_ready = (level < LVL_W'(DEPTH)) && !clr && !rst;
        push_c    = req_valid && req_ready;
        pop_c     = (level != '0) && !stall && !clr;
    end

    // Storage carries no reset; validity is owned entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_a[wr_ptr]   <= req_a;
            mem_b[wr_ptr]   <= req_b;
            mem_key[wr_ptr] <= req_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            alu_en  <= 1'b0;
            alu_clr <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_key <= '0;
            trk_v   <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                trk_k[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            alu_en  <= 1'b0;
            alu_clr <= 1'b1;
            trk_v   <= '0;
        end else begin
            alu_clr <= 1'b0;
            alu_en  <= pop_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                alu_a   <= mem_a[rd_ptr];
                alu_b   <= mem_b[rd_ptr];
                alu_key <= mem_key[rd_ptr];
            end
            if (push_c && !pop_c) begin
                level <= level + LVL_W'(1);
            end else if (!push_c && pop_c) begin
                level <= level - LVL_W'(1);
            end
            // Keys only move with a valid bit so the last stage holds done_key between pulses.
            trk_v[0] <= alu_en;
            if (alu_en) begin
                trk_k[0] <= alu_key;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                trk_v[i] <= trk_v[i-1];
                if (trk_v[i-1]) begin
                    trk_k[i] <= trk_k[i-1];
                end
            end
        end
    end

    always_comb begin
        done     = trk_v[LATENCY-1];
        done_key = trk_k[LATENCY-1];
        busy     = (level != '0) || alu_en || (|trk_v);
    end

endmodule
